ahb_resp_mux: RTL and testbench
===============================

# ahb_resp_mux

Parametrised AHB-Lite slave-response multiplexer with an integrated default slave. It registers the decoder's one-hot HSEL during the address phase and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master during the data phase. Unmapped or multiply-decoded transfers receive a protocol-correct two-cycle ERROR from the built-in default slave. It sits between the slave array and the master, replacing the fixed two-slave combinational select.

## Interface
- NUM_SLAVES, 4: number of slave ports; legal range 2..16.
- DATA_WIDTH, 32: HRDATA width; 32 or 64.
- HCLK  input  1  system clock; all state updates on the rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  NUM_SLAVES  one-hot address-phase select from the decoder.
- HTRANS  input  2  master transfer type; only bit 1 (NONSEQ/SEQ) is used.
- HRDATA_S  input  NUM_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- HREADYOUT_S  input  NUM_SLAVES  per-slave ready.
- HRESP_S  input  NUM_SLAVES  per-slave response (1 = ERROR).
- HRDATA  output  DATA_WIDTH  muxed read data to the master.
- HREADY  output  1  muxed ready; also fed back to all slaves as HREADY.
- HRESP  output  1  muxed response.
- DSEL  output  NUM_SLAVES  registered data-phase select; all zero when no slave owns the data phase.
- ERR_COUNT  output  16  default-slave error count; see Configuration.

## Operation
- Four states: IDLE (no data phase owner), SLAVE (DSEL one-hot), ERR1, ERR2.
- The address phase is sampled only on edges where HREADY=1. State does not change while HREADY=0, except for the ERR1→ERR2 step.
- The sample is classified as follows:
  - HTRANS[1]=0: go to IDLE with DSEL=0, regardless of HSEL.
  - HTRANS[1]=1 and HSEL has exactly one bit set: go to SLAVE with DSEL=HSEL.
  - HTRANS[1]=1 and HSEL is zero or has more than one bit set: go to ERR1 with DSEL=0.
- Outputs per state:
  - IDLE: HREADY=1, HRESP=0, HRDATA=0.
  - SLAVE: HRDATA, HREADY and HRESP come from the slave selected by DSEL (AND-OR mux, no priority).
  - ERR1: HREADY=0, HRESP=1, HRDATA=0.
  - ERR2: HREADY=1, HRESP=1, HRDATA=0.
- ERR1 always advances to ERR2 on the next edge. ERR2 behaves like any HREADY=1 state and samples the next address phase.
- Slave two-cycle ERROR passes through transparently. The master's cancelling IDLE in the ERROR second cycle then moves the block to IDLE.

## Timing
- Reset (HRESET=1 at an edge): state IDLE, DSEL=0, ERR_COUNT=0. Outputs are HREADY=1, HRESP=0, HRDATA=0 from the cycle after that edge.
- Reset overrides everything, including mid-ERR1/ERR2 and mid slave wait states. No ERR2 cycle is issued after reset.
- The data phase starts one HCLK after the accepted address phase. The output path is combinational from DSEL/state plus slave inputs, with zero added latency.
- Default-slave ERROR is exactly 2 cycles: ERR1 (ready low), then ERR2 (ready high).
- Back-to-back transfers to different slaves: DSEL switches on the same edge that completes the previous data phase. No bubble.
- If a slave holds HREADYOUT_S=0, DSEL and the state hold. The HSEL/HTRANS presented during wait states are ignored until the ready cycle.

## Configuration
- AHB_RESP_MUX_ERRCNT_EN defined:
  - ERR_COUNT increments by 1 on each entry to ERR1 and saturates at 16'hFFFF.
  - Cleared only by HRESET.
- Not defined: ERR_COUNT is tied to 16'h0000 and no counter flops are inferred. The default-slave behaviour is unchanged.

## Test plan
All scenarios use NUM_SLAVES=4, DATA_WIDTH=32.
- Reset: assert HRESET for 2 cycles while slave 2 drives HRDATA_S=32'hDEAD_BEEF -> HREADY=1, HRESP=0, HRDATA=0, DSEL=4'b0000, ERR_COUNT=0.
- Single read: HSEL=4'b0100, HTRANS=NONSEQ, HREADY=1; next cycle slave 2 drives 32'h1234_5678 with HREADYOUT=1 -> DSEL=4'b0100, HRDATA=32'h1234_5678, HREADY=1.
- Wait states plus back-to-back:
  - Slave 1 holds HREADYOUT_S[1]=0 for 3 cycles while the master presents HSEL=4'b1000 -> DSEL stays 4'b0010 and HREADY=0 for those 3 cycles.
  - On the ready edge -> DSEL becomes 4'b1000.
- Unmapped: HSEL=4'b0000, HTRANS=NONSEQ -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1. ERR_COUNT=1 with the macro defined, 0 without it.
- Decode fault and idle:
  - HSEL=4'b0011 with NONSEQ -> two-cycle ERROR.
  - HSEL=4'b0001 with HTRANS=IDLE -> IDLE state, HREADY=1, HRESP=0.
- Reset mid-error: assert HRESET during ERR1 -> HREADY=1, HRESP=0 on the next cycle, with no ERR2 cycle.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux: AHB-Lite slave-response multiplexer with a built-in default slave.
// It registers the one-hot HSEL during an accepted address phase. During the data
// phase it routes the owning slave's HRDATA/HREADYOUT/HRESP back to the master.
// Unmapped or multiply-decoded transfers get a two-cycle ERROR from the default slave.
// Optional feature: define AHB_RESP_MUX_ERRCNT_EN to enable the saturating
// default-slave error counter on ERR_COUNT. When it is undefined, ERR_COUNT is tied to zero.
module ahb_resp_mux #(
   parameter int NUM_SLAVES = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             HCLK,
   input  logic                             HRESET,
   input  logic [NUM_SLAVES-1:0]            HSEL,
   input  logic [1:0]                       HTRANS,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]            HRESP_S,
   output logic [DATA_WIDTH-1:0]            HRDATA,
   output logic                             HREADY,
   output logic                             HRESP,
   output logic [NUM_SLAVES-1:0]            DSEL,
   output logic [15:0]                      ERR_COUNT
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SLAVE = 2'd1,
      ST_ERR1  = 2'd2,
      ST_ERR2  = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [NUM_SLAVES-1:0] dsel_q, dsel_d;
   logic                  hsel_onehot;
   logic                  unused_htrans0;

   // Only NONSEQ/SEQ versus IDLE/BUSY matters here, so HTRANS[0] is not used.
   assign unused_htrans0 = HTRANS[0];

   // Exactly one bit set: the value is non-zero, and clearing its lowest set bit leaves zero.
   assign hsel_onehot = (HSEL != '0) &&
                        ((HSEL & (HSEL - {{(NUM_SLAVES-1){1'b0}}, 1'b1})) == '0);

   // State and data-phase select registers; reset returns to an idle bus.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q <= ST_IDLE;
         dsel_q  <= '0;
      end else begin
         state_q <= state_d;
         dsel_q  <= dsel_d;
      end
   end

   // Next state. ERR1 always steps to ERR2. Any other state samples the address phase only when HREADY is high.
   always_comb begin
      state_d = state_q;
      dsel_d  = dsel_q;
      if (state_q == ST_ERR1) begin
         state_d = ST_ERR2;
         dsel_d  = '0;
      end else if (HREADY) begin
         if (!HTRANS[1]) begin
            state_d = ST_IDLE;
            dsel_d  = '0;
         end else if (hsel_onehot) begin
            state_d = ST_SLAVE;
            dsel_d  = HSEL;
         end else begin
            state_d = ST_ERR1;
            dsel_d  = '0;
         end
      end
   end

   // Response outputs. The slave path is an AND-OR mux on DSEL, so it adds no priority and no latency.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      case (state_q)
         ST_SLAVE: begin
            HREADY = 1'b0;
            for (int i = 0; i < NUM_SLAVES; i++) begin
               HRDATA = HRDATA | (HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{dsel_q[i]}});
               HREADY = HREADY | (HREADYOUT_S[i] & dsel_q[i]);
               HRESP  = HRESP  | (HRESP_S[i] & dsel_q[i]);
            end
         end
         ST_ERR1: begin
            HREADY = 1'b0;
            HRESP  = 1'b1;
         end
         ST_ERR2: begin
            HREADY = 1'b1;
            HRESP  = 1'b1;
         end
         default: begin
            HREADY = 1'b1;
            HRESP  = 1'b0;
         end
      endcase
   end

   assign DSEL = dsel_q;

`ifdef AHB_RESP_MUX_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Count each entry into ERR1. The count saturates at all-ones. Only reset clears it.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if ((state_d == ST_ERR1) && (state_q != ST_ERR1) && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   // Error counter register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_cnt_q <= 16'h0000;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ERR_COUNT = err_cnt_q;
`else
   assign ERR_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux with NUM_SLAVES=4 and DATA_WIDTH=32.
module tb_ahb_resp_mux;

   localparam int NS = 4;
   localparam int DW = 32;
`ifdef AHB_RESP_MUX_ERRCNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic             HCLK = 1'b0;
   logic             HRESET;
   logic [NS-1:0]    HSEL;
   logic [1:0]       HTRANS;
   logic [NS*DW-1:0] HRDATA_S;
   logic [NS-1:0]    HREADYOUT_S;
   logic [NS-1:0]    HRESP_S;
   logic [DW-1:0]    HRDATA;
   logic             HREADY;
   logic             HRESP;
   logic [NS-1:0]    DSEL;
   logic [15:0]      ERR_COUNT;

   int checks   = 0;
   int failures = 0;

   ahb_resp_mux #(.NUM_SLAVES(NS), .DATA_WIDTH(DW)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
      .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .DSEL(DSEL),
      .ERR_COUNT(ERR_COUNT)
   );

   always #5 HCLK = ~HCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic set_rdata(input int idx, input logic [DW-1:0] val);
      HRDATA_S[idx*DW +: DW] = val;
   endtask

   initial begin
      HRESET = 1'b1; HSEL = 4'b0000; HTRANS = 2'b00;
      HRDATA_S = '0; HREADYOUT_S = 4'b1111; HRESP_S = 4'b0000;
      set_rdata(2, 32'hDEAD_BEEF);

      // Reset for two edges.
      tick(); tick();
      HRESET = 1'b0;
      #1;
      chk("rst_hready", HREADY, 1);
      chk("rst_hresp", HRESP, 0);
      chk("rst_hrdata", HRDATA, 0);
      chk("rst_dsel", DSEL, 4'b0000);
      chk("rst_errcnt", ERR_COUNT, 0);

      // Single read from slave 2. Slave 1's address phase is pipelined with it.
      HSEL = 4'b0100; HTRANS = 2'b10;
      tick();
      set_rdata(2, 32'h1234_5678);
      HSEL = 4'b0010; HTRANS = 2'b10;
      #1;
      chk("rd_dsel", DSEL, 4'b0100);
      chk("rd_hrdata", HRDATA, 32'h1234_5678);
      chk("rd_hready", HREADY, 1);
      chk("rd_hresp", HRESP, 0);

      // Slave 1 inserts three wait states while the master presents slave 3.
      tick();
      HREADYOUT_S = 4'b1101; HSEL = 4'b1000; HTRANS = 2'b10;
      set_rdata(1, 32'h0000_1111);
      #1;
      chk("ws1_dsel", DSEL, 4'b0010);
      chk("ws1_hready", HREADY, 0);
      tick();
      #1;
      chk("ws2_dsel", DSEL, 4'b0010);
      chk("ws2_hready", HREADY, 0);
      tick();
      #1;
      chk("ws3_dsel", DSEL, 4'b0010);
      chk("ws3_hready", HREADY, 0);
      HREADYOUT_S = 4'b1111;
      #1;
      chk("ws_ready_hready", HREADY, 1);
      chk("ws_ready_hrdata", HRDATA, 32'h0000_1111);
      // Back-to-back transfer to slave 3. The next address phase is unmapped.
      tick();
      set_rdata(3, 32'hA5A5_0003);
      HSEL = 4'b0000; HTRANS = 2'b10;
      #1;
      chk("b2b_dsel", DSEL, 4'b1000);
      chk("b2b_hrdata", HRDATA, 32'hA5A5_0003);

      // Unmapped transfer gets a two-cycle ERROR. The address presented during ERR1 is ignored.
      tick();
      HSEL = 4'b0001; HTRANS = 2'b10;
      #1;
      chk("um_err1_hready", HREADY, 0);
      chk("um_err1_hresp", HRESP, 1);
      chk("um_err1_hrdata", HRDATA, 0);
      chk("um_err1_dsel", DSEL, 4'b0000);
      chk("um_errcnt", ERR_COUNT, CNT_EN ? 1 : 0);
      tick();
      HSEL = 4'b0011; HTRANS = 2'b10;
      #1;
      chk("um_err2_hready", HREADY, 1);
      chk("um_err2_hresp", HRESP, 1);
      chk("um_err2_dsel", DSEL, 4'b0000);

      // Decode fault: multi-hot HSEL sampled in ERR2 gives another two-cycle ERROR.
      tick();
      HSEL = 4'b0001; HTRANS = 2'b00;
      #1;
      chk("df_err1_hready", HREADY, 0);
      chk("df_err1_hresp", HRESP, 1);
      chk("df_errcnt", ERR_COUNT, CNT_EN ? 2 : 0);
      tick();
      #1;
      chk("df_err2_hready", HREADY, 1);
      chk("df_err2_hresp", HRESP, 1);
      // An IDLE transfer with HSEL set goes to IDLE.
      tick();
      #1;
      chk("idle_hready", HREADY, 1);
      chk("idle_hresp", HRESP, 0);
      chk("idle_dsel", DSEL, 4'b0000);

      // Slave two-cycle ERROR passes through, followed by the master's cancelling IDLE.
      HSEL = 4'b0001; HTRANS = 2'b10;
      tick();
      HREADYOUT_S = 4'b1110; HRESP_S = 4'b0001; HSEL = 4'b0000; HTRANS = 2'b00;
      #1;
      chk("serr1_dsel", DSEL, 4'b0001);
      chk("serr1_hready", HREADY, 0);
      chk("serr1_hresp", HRESP, 1);
      tick();
      HREADYOUT_S = 4'b1111;
      #1;
      chk("serr2_hready", HREADY, 1);
      chk("serr2_hresp", HRESP, 1);
      tick();
      HRESP_S = 4'b0000;
      #1;
      chk("serr_idle_dsel", DSEL, 4'b0000);
      chk("serr_idle_hresp", HRESP, 0);

      // Reset asserted during ERR1: the next cycle is idle, and no ERR2 follows.
      HSEL = 4'b0000; HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00;
      #1;
      chk("rerr_err1_hready", HREADY, 0);
      chk("rerr_errcnt_pre", ERR_COUNT, CNT_EN ? 3 : 0);
      HRESET = 1'b1;
      tick();
      HRESET = 1'b0;
      #1;
      chk("rerr_hready", HREADY, 1);
      chk("rerr_hresp", HRESP, 0);
      chk("rerr_dsel", DSEL, 4'b0000);
      chk("rerr_errcnt", ERR_COUNT, 0);
      tick();
      #1;
      chk("rerr_no_err2_hresp", HRESP, 0);
      chk("rerr_no_err2_hready", HREADY, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
